// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode encoding and constants for the shift unit
//
// Purpose : operation-select encoding used by the top and both shift stages.
// Contents: shift_mode_t (SH_SLL, SH_SRL, SH_SRA, SH_ROTR), FINE_BITS.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_ROTR = 2'b11
    } shift_mode_t;

    // Low shift-amount bits resolved by the second (fine) stage.
    localparam int FINE_BITS = 2;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - combinational shifter used by each pipeline stage
//
// Purpose : shifts an operand by an amount according to the mode.
// Ports   : i_operand [WIDTH-1:0] operand
//           i_amount  [SHW-1:0]   shift amount, unsigned
//           i_mode    shift_mode_t operation select
//           o_result  [WIDTH-1:0] shifted result
// Macro   : SHIFT_UNIT_ROTATE_EN enables ROTR; otherwise mode 11 passes through.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_operand,
    input  logic [SHW-1:0]   i_amount,
    input  shift_mode_t      i_mode,
    output logic [WIDTH-1:0] o_result
);

`ifdef SHIFT_UNIT_ROTATE_EN
    // Left-shift distance for the wrapped part; an amount of zero gives WIDTH,
    // which shifts everything out and leaves the operand unchanged.
    logic [SHW:0] w_lshamt;
    assign w_lshamt = (SHW + 1)'(WIDTH) - {1'b0, i_amount};
`endif

    always_comb begin
        o_result = i_operand;
        case (i_mode)
            SH_SLL:  o_result = i_operand << i_amount;
            SH_SRL:  o_result = i_operand >> i_amount;
            SH_SRA:  o_result = $unsigned($signed(i_operand) >>> i_amount);
`ifdef SHIFT_UNIT_ROTATE_EN
            SH_ROTR: o_result = (i_operand >> i_amount) | (i_operand << w_lshamt);
`endif
            default: o_result = i_operand;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - two-stage pipelined barrel shifter with valid/ready handshake
//
// Purpose : stage 1 applies the coarse shift (amount bits [SHW-1:2]), stage 2
//           the fine shift (bits [1:0]) and flags an all-zero result.
// Ports   : Clk, Rst (async, active-high)
//           in_valid/in_ready, in_data [WIDTH-1:0], in_shamt [SHW-1:0],
//           in_mode [1:0] (00 SLL, 01 SRL, 10 SRA, 11 ROTR)
//           out_valid/out_ready, out_data [WIDTH-1:0], out_zero
// Macro   : SHIFT_UNIT_ROTATE_EN enables ROTR; otherwise mode 11 passes through.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_data;
    logic [FINE_BITS-1:0] r_s1_fine;
    shift_mode_t          r_s1_mode;

    logic                 r_s2_valid;
    logic [WIDTH-1:0]     r_s2_data;
    logic                 r_s2_zero;

    logic                 w_s1_adv;
    logic                 w_s2_adv;
    logic [SHW-1:0]       w_coarse_amt;
    logic [SHW-1:0]       w_fine_amt;
    logic [WIDTH-1:0]     w_coarse_res;
    logic [WIDTH-1:0]     w_fine_res;

    // Handshake depends only on registered state and out_ready, never on in_valid.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = w_s2_adv || !r_s1_valid;
    assign in_ready = !r_s1_valid || w_s1_adv;

    assign w_coarse_amt = {in_shamt[SHW-1:FINE_BITS], {FINE_BITS{1'b0}}};
    assign w_fine_amt   = {{(SHW-FINE_BITS){1'b0}}, r_s1_fine};

    // Splitting the shift composes correctly in every mode: SRA keeps the sign
    // bit in the MSB after the coarse step, and rotations add modulo WIDTH.
    shift_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_coarse (
        .i_operand (in_data),
        .i_amount  (w_coarse_amt),
        .i_mode    (shift_mode_t'(in_mode)),
        .o_result  (w_coarse_res)
    );

    shift_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_fine (
        .i_operand (r_s1_data),
        .i_amount  (w_fine_amt),
        .i_mode    (r_s1_mode),
        .o_result  (w_fine_res)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_fine  <= '0;
            r_s1_mode  <= SH_SLL;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= w_coarse_res;
                r_s1_fine <= in_shamt[FINE_BITS-1:0];
                r_s1_mode <= shift_mode_t'(in_mode);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_zero  <= 1'b1;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_fine_res;
                r_s2_zero <= ~|w_fine_res;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_zero  = r_s2_zero;

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - scoreboard bench for shift_unit with a bit-level reference model
module tb_shift_unit;
    import shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    shift_unit #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   n_pop    = 0;
    int   ir_low   = 0;
    bit   chk_lat  = 0;
    bit   rand_rdy = 0;
    bit   stream   = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: each output bit chosen directly from the operand by index arithmetic.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int sh, input int m);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            case (m)
                0:       r[i] = (i >= sh) ? d[i - sh] : 1'b0;
                1:       r[i] = (i + sh < WIDTH) ? d[i + sh] : 1'b0;
                2:       r[i] = (i + sh < WIDTH) ? d[i + sh] : d[WIDTH-1];
`ifdef SHIFT_UNIT_ROTATE_EN
                default: r[i] = d[(i + sh) % WIDTH];
`else
                default: r[i] = d[i];
`endif
            endcase
        end
        return r;
    endfunction

    // Monitor: pops and compares whenever a result is delivered.
    always @(negedge Clk) begin
        if (!Rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h want none", out_data);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_zero", {31'b0, out_zero}, {31'b0, mon_e.zero});
                if (chk_lat) check("latency", cyc - mon_e.cyc, 2);
                n_pop++;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_exp(input logic [WIDTH-1:0] e);
        sb.push_back('{e, (e == '0), cyc});
    endtask

    task automatic issue(input logic [WIDTH-1:0] d, input int sh, input int m, input logic [WIDTH-1:0] e);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SHW'(sh);
        in_mode  = 2'(m);
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge Clk);
            if (in_ready) begin
                push_exp(e);
                ok = 1;
            end else if (stream) begin
                ir_low++;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no acceptance want acceptance");
        end
    endtask

    task automatic new_op(output logic [WIDTH-1:0] d, output int sh, output int m);
        d  = ($urandom_range(0, 9) == 0) ? '0 : $urandom;
        sh = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, WIDTH - 1);
        m  = $urandom_range(0, 3);
    endtask

    task automatic drain();
        rand_rdy  = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && sb.size() > 0; k++) tick();
        tick();
        tick();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] d, held;
        int sh, m, n0, acc;

        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_mode = 2'b00;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_zero", {31'b0, out_zero}, 1);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        tick();

        // Directed cases with fixed expected values.
        chk_lat = 1; out_ready = 1'b1;
        issue(32'h0000_0001, 31, 0, 32'h8000_0000);
        issue(32'h8000_00F0, 4, 2, 32'hF800_000F);
        issue(32'h8000_00F0, 4, 1, 32'h0800_000F);
`ifdef SHIFT_UNIT_ROTATE_EN
        issue(32'h0000_00FF, 8, 3, 32'hFF00_0000);
        issue(32'h0000_0001, 1, 3, 32'h8000_0000);
`else
        issue(32'h0000_00FF, 8, 3, 32'h0000_00FF);
`endif
        for (int k = 0; k < 4; k++) issue(32'hA5C3_0F96, 0, k, 32'hA5C3_0F96);
        issue(32'h0000_0001, 1, 1, 32'h0000_0000);
        issue(32'h7FFF_FFFF, 31, 2, 32'h0000_0000);
        drain();

        // Back-to-back streaming.
        n0 = n_pop; ir_low = 0; stream = 1;
        for (int k = 0; k < 16; k++) begin
            new_op(d, sh, m);
            issue(d, sh, m, model(d, sh, m));
        end
        stream = 0;
        drain();
        check("stream_in_ready_low", ir_low, 0);
        check("stream_count", n_pop - n0, 16);

        // Backpressure: downstream stalls for 5 cycles.
        chk_lat = 0; out_ready = 1'b0; n0 = n_pop; acc = 0; held = '0;
        new_op(d, sh, m);
        in_valid = 1'b1; in_data = d; in_shamt = SHW'(sh); in_mode = 2'(m);
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (k == 2) held = out_data;
            if (in_ready) begin
                push_exp(model(d, sh, m));
                acc++;
                new_op(d, sh, m);
            end
            tick();
            in_data = d; in_shamt = SHW'(sh); in_mode = 2'(m);
        end
        @(negedge Clk);
        check("bp_accepted", acc, 2);
        check("bp_in_ready", {31'b0, in_ready}, 0);
        check("bp_out_valid", {31'b0, out_valid}, 1);
        check("bp_out_held", out_data, held);
        tick();
        out_ready = 1'b1;
        issue(d, sh, m, model(d, sh, m));
        drain();
        check("bp_count", n_pop - n0, 3);

        // Randomized traffic with random downstream readiness.
        rand_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            new_op(d, sh, m);
            issue(d, sh, m, model(d, sh, m));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();

        // Reset with both stages full.
        chk_lat = 1; out_ready = 1'b0;
        issue(32'h1234_5678, 3, 0, 32'h0);
        issue(32'h8765_4321, 5, 1, 32'h0);
        Rst = 1'b1;
        sb.delete();
        @(negedge Clk);
        check("mid_rst_out_valid", {31'b0, out_valid}, 0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        check("mid_rst_out_zero", {31'b0, out_zero}, 1);
        check("mid_rst_out_data", out_data, 0);
        tick();
        n0 = n_pop;
        issue(32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF);
        drain();
        check("post_rst_count", n_pop - n0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
